// File: rtl/ras_ckpt.sv
// ras_ckpt: return address stack with one-level speculative checkpoint/repair.
//   Calls push a return address and returns pop it. A JALR that both returns
//   and links does both, which replaces the top entry. A flush restores
//   {tos, count, top entry} from the last checkpoint, so wrong-path activity
//   does not corrupt the stack.
// Ports:
//   CLK, RESET          clock, asynchronous active-high reset
//   Push_IN/Push_addr_IN push a return address
//   Pop_IN              pop the top entry
//   Ckpt_save_IN        capture post-update {tos, count, top} as the checkpoint
//   Flush_IN            restore state from the checkpoint (highest priority)
//   Valid_OUT/Addr_OUT  top-of-stack prediction (Addr_OUT is 0 when empty)
//   Count_OUT, Full_OUT, Empty_OUT  occupancy status
// Optional: define RAS_STATS_EN to add Ovf_cnt_OUT/Unf_cnt_OUT event counters.
module ras_ckpt #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              Push_IN,
   input  logic [ADDR_W-1:0] Push_addr_IN,
   input  logic              Pop_IN,
   input  logic              Ckpt_save_IN,
   input  logic              Flush_IN,
   output logic              Valid_OUT,
   output logic [ADDR_W-1:0] Addr_OUT,
   output logic [CNT_W-1:0]  Count_OUT,
   output logic              Full_OUT,
   output logic              Empty_OUT
`ifdef RAS_STATS_EN
   ,
   output logic [15:0]       Ovf_cnt_OUT,
   output logic [15:0]       Unf_cnt_OUT
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   logic [ADDR_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_tos;
   logic [CNT_W-1:0]  r_count;

   logic [PTR_W-1:0]  r_ck_tos;
   logic [CNT_W-1:0]  r_ck_count;
   logic [ADDR_W-1:0] r_ck_top;

   logic              w_full;
   logic              w_empty;
   logic [ADDR_W-1:0] w_top;
   logic [PTR_W-1:0]  w_tos_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic              w_wr_en;
   logic [PTR_W-1:0]  w_wr_idx;
   logic [ADDR_W-1:0] w_wr_data;
   logic [ADDR_W-1:0] w_top_nxt;
   logic              w_ovf;
   logic              w_unf;

   assign w_full  = (r_count == CNT_W'(DEPTH));
   assign w_empty = (r_count == '0);
   assign w_top   = r_mem[r_tos];

   // Status and prediction straight from registered state.
   assign Valid_OUT = ~w_empty;
   assign Addr_OUT  = w_empty ? '0 : w_top;
   assign Count_OUT = r_count;
   assign Full_OUT  = w_full;
   assign Empty_OUT = w_empty;

   // Next-state selection in priority order: flush, push, pop, return-and-link.
   always_comb begin
      w_tos_nxt = r_tos;
      w_cnt_nxt = r_count;
      w_wr_en   = 1'b0;
      w_wr_idx  = r_tos;
      w_wr_data = Push_addr_IN;
      w_ovf     = 1'b0;
      w_unf     = 1'b0;
      if (Flush_IN) begin
         w_tos_nxt = r_ck_tos;
         w_cnt_nxt = r_ck_count;
         w_wr_en   = 1'b1;
         w_wr_idx  = r_ck_tos;
         w_wr_data = r_ck_top;
      end else if (Push_IN && (!Pop_IN || w_empty)) begin
         // Plain push, or return-and-link on an empty stack.
         w_tos_nxt = r_tos + PTR_W'(1);
         w_wr_en   = 1'b1;
         w_wr_idx  = r_tos + PTR_W'(1);
         w_cnt_nxt = w_full ? r_count : r_count + CNT_W'(1);
         w_ovf     = w_full;
      end else if (Push_IN && Pop_IN) begin
         w_wr_en = 1'b1;
      end else if (Pop_IN) begin
         if (!w_empty) begin
            w_tos_nxt = r_tos - PTR_W'(1);
            w_cnt_nxt = r_count - CNT_W'(1);
         end else begin
            w_unf = 1'b1;
         end
      end
   end

   // Top entry as it will look after this edge, for the checkpoint.
   assign w_top_nxt = (w_wr_en && (w_wr_idx == w_tos_nxt)) ? w_wr_data : r_mem[w_tos_nxt];

   // Storage array has no reset; contents are qualified by count.
   always_ff @(posedge CLK) begin
      if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
   end

   // Pointer, occupancy and checkpoint registers.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_tos      <= '0;
         r_count    <= '0;
         r_ck_tos   <= '0;
         r_ck_count <= '0;
         r_ck_top   <= '0;
      end else begin
         r_tos   <= w_tos_nxt;
         r_count <= w_cnt_nxt;
         if (!Flush_IN && Ckpt_save_IN) begin
            r_ck_tos   <= w_tos_nxt;
            r_ck_count <= w_cnt_nxt;
            r_ck_top   <= w_top_nxt;
         end
      end
   end

`ifdef RAS_STATS_EN
   logic [15:0] r_ovf_cnt;
   logic [15:0] r_unf_cnt;

   assign Ovf_cnt_OUT = r_ovf_cnt;
   assign Unf_cnt_OUT = r_unf_cnt;

   // Saturating overflow/underflow event counters; flush cycles never count.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         r_ovf_cnt <= '0;
         r_unf_cnt <= '0;
      end else begin
         if (w_ovf && (r_ovf_cnt != 16'hFFFF)) r_ovf_cnt <= r_ovf_cnt + 16'd1;
         if (w_unf && (r_unf_cnt != 16'hFFFF)) r_unf_cnt <= r_unf_cnt + 16'd1;
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge CLK) begin
      if (!RESET && w_ovf) $display("ras_ckpt: overflow, oldest entry overwritten");
      if (!RESET && w_unf) $display("ras_ckpt: underflow, pop on empty stack");
   end
`endif
`endif

endmodule

// File: tb/tb_ras_ckpt.sv
module tb_ras_ckpt;

   localparam int DEPTH  = 4;
   localparam int ADDR_W = 32;
   localparam int CNT_W  = 3;

   logic              CLK;
   logic              RESET;
   logic              Push_IN;
   logic [ADDR_W-1:0] Push_addr_IN;
   logic              Pop_IN;
   logic              Ckpt_save_IN;
   logic              Flush_IN;
   logic              Valid_OUT;
   logic [ADDR_W-1:0] Addr_OUT;
   logic [CNT_W-1:0]  Count_OUT;
   logic              Full_OUT;
   logic              Empty_OUT;
`ifdef RAS_STATS_EN
   logic [15:0]       Ovf_cnt_OUT;
   logic [15:0]       Unf_cnt_OUT;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   logic [37:0] obs;
   logic [37:0] exp_s;

   ras_ckpt #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .Push_IN      (Push_IN),
      .Push_addr_IN (Push_addr_IN),
      .Pop_IN       (Pop_IN),
      .Ckpt_save_IN (Ckpt_save_IN),
      .Flush_IN     (Flush_IN),
      .Valid_OUT    (Valid_OUT),
      .Addr_OUT     (Addr_OUT),
      .Count_OUT    (Count_OUT),
      .Full_OUT     (Full_OUT),
      .Empty_OUT    (Empty_OUT)
`ifdef RAS_STATS_EN
      ,
      .Ovf_cnt_OUT  (Ovf_cnt_OUT),
      .Unf_cnt_OUT  (Unf_cnt_OUT)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   assign obs = {Valid_OUT, Addr_OUT, Count_OUT, Full_OUT, Empty_OUT};

   // Expected observable state {valid, addr, count, full, empty}.
   function automatic logic [37:0] st(input logic [31:0] a, input int c);
      logic v, f, e;
      v = (c != 0);
      f = (c == DEPTH);
      e = (c == 0);
      return {v, (v ? a : 32'h0), 3'(c), f, e};
   endfunction

   // One clock with the given controls; returns 1 time unit after the edge.
   task automatic cyc(input logic push, input logic [31:0] addr, input logic pop,
                      input logic save, input logic flush);
      Push_IN = push; Push_addr_IN = addr; Pop_IN = pop;
      Ckpt_save_IN = save; Flush_IN = flush;
      @(posedge CLK); #1;
      Push_IN = 1'b0; Push_addr_IN = '0; Pop_IN = 1'b0;
      Ckpt_save_IN = 1'b0; Flush_IN = 1'b0;
   endtask

   task automatic do_reset;
      RESET = 1'b1;
      @(posedge CLK); #1;
      RESET = 1'b0;
   endtask

   task automatic test_reset;
      do_reset();
      exp_s = st(0, 0); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL reset_state: got %h want %h", obs, exp_s); end
      // Flush with no save since reset yields empty.
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      exp_s = st(0, 0); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL reset_flush: got %h want %h", obs, exp_s); end
   endtask

   task automatic test_push_pop;
      logic [31:0] want_a [3];
      want_a = '{32'h200, 32'h100, 32'h0};
      do_reset();
      cyc(1'b1, 32'h100, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h200, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h300, 1'b0, 1'b0, 1'b0);
      exp_s = st(32'h300, 3); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL push3: got %h want %h", obs, exp_s); end
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
         exp_s = st(want_a[i], 2 - i); n_tests++;
         if (obs !== exp_s) begin n_fail++; $display("FAIL pop%0d: got %h want %h", i, obs, exp_s); end
      end
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      exp_s = st(0, 0); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL underflow: got %h want %h", obs, exp_s); end
`ifdef RAS_STATS_EN
      n_tests++;
      if (Unf_cnt_OUT !== 16'd1) begin n_fail++; $display("FAIL unf_cnt: got %0d want 1", Unf_cnt_OUT); end
`endif
      // Push after underflow lands at a sane slot.
      cyc(1'b1, 32'h444, 1'b0, 1'b0, 1'b0);
      exp_s = st(32'h444, 1); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL push_after_unf: got %h want %h", obs, exp_s); end
   endtask

   task automatic test_overflow;
      logic [31:0] want_a [4];
      want_a = '{32'h40, 32'h30, 32'h20, 32'h0};
      do_reset();
      for (int i = 1; i <= 5; i++) cyc(1'b1, 32'(i * 16), 1'b0, 1'b0, 1'b0);
      exp_s = st(32'h50, 4); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL overflow_full: got %h want %h", obs, exp_s); end
`ifdef RAS_STATS_EN
      n_tests++;
      if (Ovf_cnt_OUT !== 16'd1) begin n_fail++; $display("FAIL ovf_cnt: got %0d want 1", Ovf_cnt_OUT); end
`endif
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
         exp_s = st(want_a[i], 3 - i); n_tests++;
         if (obs !== exp_s) begin n_fail++; $display("FAIL ovf_pop%0d: got %h want %h", i, obs, exp_s); end
      end
   endtask

   task automatic test_return_link;
      do_reset();
      cyc(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hC0, 1'b1, 1'b0, 1'b0);
      exp_s = st(32'hC0, 2); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL rl_replace: got %h want %h", obs, exp_s); end
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      exp_s = st(32'hA0, 1); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL rl_pop: got %h want %h", obs, exp_s); end
      // Return-and-link on empty stack acts as a push.
      do_reset();
      cyc(1'b1, 32'hE1, 1'b1, 1'b0, 1'b0);
      exp_s = st(32'hE1, 1); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL rl_empty: got %h want %h", obs, exp_s); end
   endtask

   task automatic test_checkpoint;
      do_reset();
      cyc(1'b1, 32'hA0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 32'hDD, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hEE, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      exp_s = st(32'hDD, 2); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL wrong_path: got %h want %h", obs, exp_s); end
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      exp_s = st(32'hB0, 2); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL ckpt_flush: got %h want %h", obs, exp_s); end
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      exp_s = st(32'hA0, 1); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL ckpt_pop: got %h want %h", obs, exp_s); end
   endtask

   task automatic test_save_with_push;
      do_reset();
      cyc(1'b1, 32'h11, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'h22, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      exp_s = st(32'h11, 1); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL save_post_push: got %h want %h", obs, exp_s); end
   endtask

   task automatic test_flush_priority;
      do_reset();
      cyc(1'b1, 32'hA0, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 32'hB0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'hFF, 1'b0, 1'b1, 1'b1);
      exp_s = st(32'hA0, 1); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL flush_prio: got %h want %h", obs, exp_s); end
      // Save on the flush cycle must not have captured the ignored push.
      cyc(1'b1, 32'h77, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 32'h88, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      exp_s = st(32'hA0, 1); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL flush_prio_ckpt: got %h want %h", obs, exp_s); end
   endtask

   task automatic test_async_reset;
      do_reset();
      cyc(1'b1, 32'h100, 1'b0, 1'b1, 1'b0);
      exp_s = st(32'h100, 1); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL pre_async: got %h want %h", obs, exp_s); end
      #3 RESET = 1'b1;
      #1;
      exp_s = st(0, 0); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL async_reset: got %h want %h", obs, exp_s); end
      #1 RESET = 1'b0;
      cyc(1'b0, 0, 1'b0, 1'b0, 1'b1);
      exp_s = st(0, 0); n_tests++;
      if (obs !== exp_s) begin n_fail++; $display("FAIL async_flush: got %h want %h", obs, exp_s); end
   endtask

   initial begin
      RESET = 1'b1; Push_IN = 1'b0; Push_addr_IN = '0; Pop_IN = 1'b0;
      Ckpt_save_IN = 1'b0; Flush_IN = 1'b0;
      #2;
      test_reset();
      test_push_pop();
      test_overflow();
      test_return_link();
      test_checkpoint();
      test_save_with_push();
      test_flush_priority();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
